// File: rtl/ip_decap_rx_ctrl.sv
// Receive-side IP decapsulation controller: accepts one parsed outer header,
// runs the reverse CAM lookup, then forwards or drains the payload and emits metadata.
module ip_decap_rx_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src_ip_decap_rx_meta_val,
  output logic        ip_decap_src_rx_meta_rdy,
  input  logic        src_ip_decap_rx_data_val,
  input  logic        src_ip_decap_rx_data_last,
  output logic        ip_decap_src_rx_data_rdy,
  output logic        ip_decap_dst_rx_meta_val,
  input  logic        dst_ip_decap_rx_meta_rdy,
  output logic        ip_decap_dst_rx_data_val,
  output logic        ip_decap_dst_rx_data_last,
  input  logic        dst_ip_decap_rx_data_rdy,
  output logic        ctrl_datap_store_hdr,
  output logic        ctrl_datap_store_ips,
  input  logic        datap_ctrl_hdr_ok,
  output logic        ctrl_ip_dir_cam_read_val,
  input  logic        ip_dir_cam_ctrl_read_hit,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    READY   = 3'd0,
    LOOKUP  = 3'd1,
    OUTPUT  = 3'd2,
    DRAIN   = 3'd3,
    TX_WAIT = 3'd4
  } main_state_e;

  typedef enum logic [1:0] {
    WAITING      = 2'd0,
    META_OUT     = 2'd1,
    META_TX_WAIT = 2'd2
  } meta_state_e;

  main_state_e main_q, main_d;
  meta_state_e meta_q, meta_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        out_en_q, out_en_d;
  logic        meta_req;

  // out_en_q keeps the READY-state handshakes low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= READY;
      meta_q     <= WAITING;
      drop_cnt_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      main_q     <= main_d;
      meta_q     <= meta_d;
      drop_cnt_q <= drop_cnt_d;
      out_en_q   <= out_en_d;
    end
  end

  always_comb begin
    main_d     = main_q;
    meta_req   = 1'b0;
    drop_cnt_d = drop_cnt_q;
    out_en_d   = 1'b1;
    case (main_q)
      READY:   if (src_ip_decap_rx_meta_val && out_en_q) main_d = LOOKUP;
      LOOKUP: begin
        if (datap_ctrl_hdr_ok && ip_dir_cam_ctrl_read_hit) begin
          main_d   = OUTPUT;
          meta_req = 1'b1;
        end else begin
          main_d = DRAIN;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      OUTPUT:  if (src_ip_decap_rx_data_val && dst_ip_decap_rx_data_rdy &&
                   src_ip_decap_rx_data_last) main_d = TX_WAIT;
      DRAIN:   if (src_ip_decap_rx_data_val && src_ip_decap_rx_data_last) main_d = READY;
      TX_WAIT: if (meta_q == META_TX_WAIT) main_d = READY;
      default: begin
        main_d     = main_state_e'('x);
        meta_req   = 1'bx;
        drop_cnt_d = 'x;
      end
    endcase
  end

  always_comb begin
    meta_d = meta_q;
    case (meta_q)
      WAITING:      if (meta_req) meta_d = META_OUT;
      META_OUT:     if (dst_ip_decap_rx_meta_rdy) meta_d = META_TX_WAIT;
      META_TX_WAIT: if (main_q == TX_WAIT) meta_d = WAITING;
      default:      meta_d = meta_state_e'('x);
    endcase
  end

  always_comb begin
    ip_decap_src_rx_meta_rdy  = 1'b0;
    ip_decap_src_rx_data_rdy  = 1'b0;
    ip_decap_dst_rx_meta_val  = 1'b0;
    ip_decap_dst_rx_data_val  = 1'b0;
    ip_decap_dst_rx_data_last = 1'b0;
    ctrl_datap_store_hdr      = 1'b0;
    ctrl_datap_store_ips      = 1'b0;
    ctrl_ip_dir_cam_read_val  = 1'b0;
    case (main_q)
      READY: begin
        ip_decap_src_rx_meta_rdy = out_en_q;
        ctrl_datap_store_hdr     = out_en_q;
      end
      LOOKUP: begin
        ctrl_ip_dir_cam_read_val = 1'b1;
        ctrl_datap_store_ips     = 1'b1;
      end
      OUTPUT: begin
        ip_decap_dst_rx_data_val  = src_ip_decap_rx_data_val;
        ip_decap_dst_rx_data_last = src_ip_decap_rx_data_last;
        ip_decap_src_rx_data_rdy  = dst_ip_decap_rx_data_rdy;
      end
      DRAIN:   ip_decap_src_rx_data_rdy = 1'b1;
      TX_WAIT: ;
      default: begin
        ip_decap_src_rx_meta_rdy  = 1'bx;
        ip_decap_src_rx_data_rdy  = 1'bx;
        ip_decap_dst_rx_data_val  = 1'bx;
        ip_decap_dst_rx_data_last = 1'bx;
        ctrl_datap_store_hdr      = 1'bx;
        ctrl_datap_store_ips      = 1'bx;
        ctrl_ip_dir_cam_read_val  = 1'bx;
      end
    endcase
    case (meta_q)
      WAITING, META_TX_WAIT: ;
      META_OUT: ip_decap_dst_rx_meta_val = 1'b1;
      default:  ip_decap_dst_rx_meta_val = 1'bx;
    endcase
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ip_decap_rx_ctrl.sv
// Bench for ip_decap_rx_ctrl: directed and randomized packets checked against a
// packet-level model (forward or drop, one metadata per forwarded packet, saturating drop count).
module tb_ip_decap_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_meta_val, src_meta_rdy;
  logic        src_data_val, src_data_last, src_data_rdy;
  logic        dst_meta_val, dst_meta_rdy;
  logic        dst_data_val, dst_data_last, dst_data_rdy;
  logic        store_hdr, store_ips, hdr_ok, cam_read, cam_hit;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_miss = 0;
  int model_drops = 0;

  int r_src, r_dst, r_last_at, r_lasts, r_meta, r_cam, r_tout, r_held, r_settle;

  always #5 clk = ~clk;

  ip_decap_rx_ctrl dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .src_ip_decap_rx_meta_val  (src_meta_val),
    .ip_decap_src_rx_meta_rdy  (src_meta_rdy),
    .src_ip_decap_rx_data_val  (src_data_val),
    .src_ip_decap_rx_data_last (src_data_last),
    .ip_decap_src_rx_data_rdy  (src_data_rdy),
    .ip_decap_dst_rx_meta_val  (dst_meta_val),
    .dst_ip_decap_rx_meta_rdy  (dst_meta_rdy),
    .ip_decap_dst_rx_data_val  (dst_data_val),
    .ip_decap_dst_rx_data_last (dst_data_last),
    .dst_ip_decap_rx_data_rdy  (dst_data_rdy),
    .ctrl_datap_store_hdr      (store_hdr),
    .ctrl_datap_store_ips      (store_ips),
    .datap_ctrl_hdr_ok         (hdr_ok),
    .ctrl_ip_dir_cam_read_val  (cam_read),
    .ip_dir_cam_ctrl_read_hit  (cam_hit),
    .drop_cnt                  (drop_cnt)
  );

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask

  // bp: percent chance dst data rdy is low; -1 gives the alternating 1,0,1,0 pattern.
  // mlast=0: dst meta rdy from cycle mdly on; mlast=1: mdly cycles after the last beat.
  task automatic run_pkt(input int n, input bit ok, input bit hit, input int bp,
                         input int mdly, input bit mlast);
    int  beat, cyc, last_cyc, done_cyc;
    bit  meta_acc, meta_hs, good;
    good = ok && hit;
    beat = 0; last_cyc = -1; done_cyc = -1; meta_acc = 0; meta_hs = 0;
    r_src = 0; r_dst = 0; r_last_at = 0; r_lasts = 0; r_meta = 0; r_cam = 0;
    r_tout = 0; r_held = 0; r_settle = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      src_meta_val  = !meta_acc;
      hdr_ok        = ok;
      cam_hit       = hit;
      src_data_val  = (beat < n);
      src_data_last = (beat == n - 1);
      if (bp < 0) dst_data_rdy = (cyc % 2 == 0);
      else        dst_data_rdy = ($urandom_range(99) >= bp);
      if (mlast) dst_meta_rdy = (last_cyc >= 0) && (cyc - last_cyc >= mdly);
      else       dst_meta_rdy = (cyc >= mdly);
      #1;
      if (done_cyc >= 0 && src_meta_rdy) begin
        r_settle = cyc - done_cyc;
        break;
      end
      if (mlast && last_cyc >= 0 && !meta_hs && dst_meta_val && !src_meta_rdy) r_held++;
      if (cam_read) r_cam++;
      if (src_meta_val && src_meta_rdy) meta_acc = 1;
      if (src_data_val && src_data_rdy) begin
        r_src++;
        beat++;
        if (beat == n) last_cyc = cyc;
      end
      if (dst_data_val && dst_data_rdy) begin
        r_dst++;
        if (dst_data_last) begin
          r_lasts++;
          r_last_at = r_dst;
        end
      end
      if (dst_meta_val && dst_meta_rdy) begin
        r_meta++;
        meta_hs = 1;
      end
      if (done_cyc < 0 && meta_acc && beat == n && (meta_hs || !good)) done_cyc = cyc;
    end
    if (cyc >= 400) r_tout = 1;
    src_meta_val = 0;
    src_data_val = 0;
    src_data_last = 0;
  endtask

  task automatic check_pkt(input string t, input int n, input bit ok, input bit hit);
    bit good;
    good = ok && hit;
    if (!good && model_drops < 65535) model_drops++;
    chk({t, ".tout"},      r_tout, 0);
    chk({t, ".src_beats"}, r_src, n);
    chk({t, ".dst_beats"}, r_dst, good ? n : 0);
    chk({t, ".last_pos"},  r_last_at, good ? n : 0);
    chk({t, ".dst_lasts"}, r_lasts, good ? 1 : 0);
    chk({t, ".dst_meta"},  r_meta, good ? 1 : 0);
    chk({t, ".cam_reads"}, r_cam, 1);
    chk({t, ".settle"},    (r_settle >= 1 && r_settle <= 2), 1);
    chk({t, ".drop_cnt"},  drop_cnt, model_drops);
  endtask

  initial begin
    int n, beats;
    bit ok, hit, acc;
    rst_n = 0;
    src_meta_val = 0; src_data_val = 0; src_data_last = 0;
    dst_meta_rdy = 0; dst_data_rdy = 0; hdr_ok = 0; cam_hit = 0;

    #2;
    chk("rst.meta_rdy", src_meta_rdy, 0);
    chk("rst.store_hdr", store_hdr, 0);
    chk("rst.outs", {src_data_rdy, dst_meta_val, dst_data_val, dst_data_last,
                     store_ips, cam_read}, 0);
    chk("rst.drop_cnt", drop_cnt, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("rst.meta_rdy_pre_edge", src_meta_rdy, 0);
    @(posedge clk); #1;
    chk("rst.meta_rdy_post", src_meta_rdy, 1);
    chk("rst.store_hdr_post", store_hdr, 1);

    run_pkt(3, 1, 1, 0, 0, 0);    check_pkt("good3", 3, 1, 1);
    run_pkt(4, 1, 0, 0, 0, 0);    check_pkt("miss4", 4, 1, 0);
    run_pkt(2, 0, 1, 0, 0, 0);    check_pkt("badhdr", 2, 0, 1);
    run_pkt(3, 1, 1, 0, 11, 1);   check_pkt("metawait", 3, 1, 1);
    chk("metawait.held", r_held, 11);
    chk("metawait.settle", r_settle, 2);
    run_pkt(2, 1, 1, -1, 0, 0);   check_pkt("toggle", 2, 1, 1);
    run_pkt(1, 1, 1, 0, 0, 0);    check_pkt("single_good", 1, 1, 1);
    run_pkt(1, 1, 0, 0, 0, 0);    check_pkt("single_drop", 1, 1, 0);

    for (int i = 0; i < 30; i++) begin
      n   = $urandom_range(6, 1);
      ok  = ($urandom_range(3) != 0);
      hit = ($urandom_range(3) != 0);
      run_pkt(n, ok, hit, $urandom_range(60), $urandom_range(6), $urandom_range(1));
      check_pkt($sformatf("rnd%0d", i), n, ok, hit);
    end

    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFD;
    #1;
    release dut.drop_cnt_q;
    model_drops = 65533;
    #1;
    chk("sat.preload", drop_cnt, 16'hFFFD);
    for (int i = 0; i < 3; i++) begin
      run_pkt(1, 0, 0, 0, 0, 0);
      check_pkt($sformatf("sat%0d", i), 1, 0, 0);
    end
    chk("sat.final", drop_cnt, 16'hFFFF);

    acc = 0; beats = 0;
    for (int k = 0; k < 20 && beats < 1; k++) begin
      @(negedge clk);
      src_meta_val = !acc; hdr_ok = 1; cam_hit = 1;
      src_data_val = 1; src_data_last = 0; dst_data_rdy = 1; dst_meta_rdy = 0;
      #1;
      if (src_meta_val && src_meta_rdy) acc = 1;
      if (src_data_val && src_data_rdy) beats++;
    end
    chk("midrst.beat1", beats, 1);
    @(negedge clk);
    src_meta_val = 0; src_data_val = 1; src_data_last = 0;
    #1;
    chk("midrst.beat2_val", dst_data_val, 1);
    rst_n = 0;
    #1;
    chk("midrst.dst_val", dst_data_val, 0);
    chk("midrst.src_rdy", src_data_rdy, 0);
    chk("midrst.meta_val", dst_meta_val, 0);
    chk("midrst.meta_rdy", src_meta_rdy, 0);
    chk("midrst.drop_cnt", drop_cnt, 0);
    model_drops = 0;
    @(negedge clk);
    src_data_val = 0; dst_data_rdy = 0;
    rst_n = 1;
    @(posedge clk); #1;
    chk("midrst.ready", src_meta_rdy, 1);
    chk("midrst.meta_idle", dst_meta_val, 0);
    run_pkt(2, 1, 1, 20, 1, 0);   check_pkt("after_rst", 2, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
